// File: rtl/bp_fpga_host_pkg.sv
// Shared NBF host definitions: opcodes, packet width/struct macros, Tx FSM states.
// Checksum byte per packet is enabled with BP_FPGA_HOST_NBF_TX_CHECKSUM_EN.
`ifndef BP_FPGA_HOST_PKG_SV
`define BP_FPGA_HOST_PKG_SV

`define BP_FPGA_HOST_NBF_WIDTH(op_w, addr_w, data_w) ((op_w) + (addr_w) + (data_w))

`define DECLARE_BP_FPGA_HOST_NBF_S(op_w, addr_w, data_w) \
  typedef struct packed {                                  \
    logic [(data_w)-1:0] data;                             \
    logic [(addr_w)-1:0] addr;                             \
    logic [(op_w)-1:0]   opcode;                           \
  } bp_fpga_host_nbf_s

package bp_fpga_host_pkg;

  typedef enum logic [7:0] {
    e_nbf_write  = 8'h03,
    e_nbf_fence  = 8'hFE,
    e_nbf_finish = 8'hFF
  } bp_fpga_host_nbf_opcode_e;

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_send = 2'd1,
    e_wait = 2'd2
  } bp_fpga_host_nbf_tx_state_e;

  function automatic int nbf_bytes(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

`endif

// File: rtl/bp_fpga_host_uart_serializer.sv
// UART byte framer: start, 8 data LSB first, optional even parity, 1-2 stop bits.
// Checksum option (BP_FPGA_HOST_NBF_TX_CHECKSUM_EN) does not affect this block.
module bp_fpga_host_uart_serializer
  import bp_fpga_host_pkg::*;
#(
  parameter int clk_per_bit_p = 10416,
  parameter int parity_bit_p  = 0,
  parameter int stop_bits_p   = 1
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [7:0] data_i,
  input  logic       v_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int FB = 9 + parity_bit_p + stop_bits_p;
  localparam int CW = $clog2(clk_per_bit_p);
  localparam int BW = $clog2(FB);

  logic [FB-1:0] frame_w, frame_q;
  logic [CW-1:0] cyc_q;
  logic [BW-1:0] left_q;
  logic          active_q, tx_q, done_q;

  // Stop bits are the default ones; parity overwrites bit 9 when enabled.
  always_comb begin
    frame_w      = '1;
    frame_w[0]   = 1'b0;
    frame_w[8:1] = data_i;
    if (parity_bit_p != 0) frame_w[9] = ^data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      active_q <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      cyc_q    <= '0;
      left_q   <= '0;
      frame_q  <= '1;
    end else begin
      done_q <= 1'b0;
      if (!active_q) begin
        if (v_i) begin
          active_q <= 1'b1;
          tx_q     <= 1'b0;
          frame_q  <= frame_w >> 1;
          cyc_q    <= '0;
          left_q   <= BW'(FB - 1);
        end
      end else if (cyc_q == CW'(clk_per_bit_p - 1)) begin
        cyc_q <= '0;
        if (left_q == '0) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
          tx_q     <= 1'b1;
        end else begin
          tx_q    <= frame_q[0];
          frame_q <= frame_q >> 1;
          left_q  <= left_q - 1'b1;
        end
      end else begin
        cyc_q <= cyc_q + 1'b1;
      end
    end
  end

  assign ready_o = !active_q;
  assign busy_o  = active_q;
  assign tx_o    = tx_q;
  assign done_o  = done_q;

endmodule

// File: rtl/bp_fpga_host_nbf_tx.sv
// Buffered NBF packet to UART transmitter: packet FIFO, byte segmenter FSM, serializer.
// Define BP_FPGA_HOST_NBF_TX_CHECKSUM_EN to append an XOR checksum byte per packet.
module bp_fpga_host_nbf_tx
  import bp_fpga_host_pkg::*;
#(
  parameter int nbf_opcode_width_p = 8,
  parameter int nbf_addr_width_p   = 40,
  parameter int nbf_data_width_p   = 64,
  parameter int buffer_els_p       = 2,
  parameter int uart_clk_per_bit_p = 10416,
  parameter int uart_parity_bit_p  = 0,
  parameter int uart_stop_bits_p   = 1
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic [`BP_FPGA_HOST_NBF_WIDTH(nbf_opcode_width_p, nbf_addr_width_p, nbf_data_width_p)-1:0] nbf_i,
  input  logic        nbf_v_i,
  output logic        nbf_ready_and_o,
  output logic        tx_o,
  output logic        busy_o,
  output logic        pkt_done_o,
  output logic [15:0] pkt_count_o
);

  localparam int NBF_W = `BP_FPGA_HOST_NBF_WIDTH(nbf_opcode_width_p, nbf_addr_width_p, nbf_data_width_p);
  localparam int OP_B  = nbf_bytes(nbf_opcode_width_p);
  localparam int AD_B  = nbf_bytes(nbf_addr_width_p);
  localparam int DA_B  = nbf_bytes(nbf_data_width_p);
  localparam int N     = OP_B + AD_B + DA_B;
  localparam int SW    = N * 8;
`ifdef BP_FPGA_HOST_NBF_TX_CHECKSUM_EN
  localparam int TOT   = N + 1;
`else
  localparam int TOT   = N;
`endif
  localparam int CNT_W = $clog2(TOT + 1);
  localparam int FC_W  = $clog2(buffer_els_p + 1);
  localparam int PW    = (buffer_els_p > 1) ? $clog2(buffer_els_p) : 1;

  `DECLARE_BP_FPGA_HOST_NBF_S(nbf_opcode_width_p, nbf_addr_width_p, nbf_data_width_p);

  // Packet FIFO
  logic [NBF_W-1:0] mem_q [buffer_els_p];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [FC_W-1:0]  fcnt_q;
  logic             full, empty, enq, deq;

  assign full            = (fcnt_q == FC_W'(buffer_els_p));
  assign empty           = (fcnt_q == '0);
  assign nbf_ready_and_o = reset_n_i & !full;
  assign enq             = nbf_v_i & nbf_ready_and_o;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (enq) begin
        mem_q[wr_ptr_q] <= nbf_i;
        wr_ptr_q <= (wr_ptr_q == PW'(buffer_els_p - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (deq) rd_ptr_q <= (rd_ptr_q == PW'(buffer_els_p - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({enq, deq})
        2'b10:   fcnt_q <= fcnt_q + 1'b1;
        2'b01:   fcnt_q <= fcnt_q - 1'b1;
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  // Byte-align each field so the shift register streams opcode, addr, data LSB first.
  bp_fpga_host_nbf_s head;
  logic [SW-1:0]     head_bytes;
  assign head = bp_fpga_host_nbf_s'(mem_q[rd_ptr_q]);

  always_comb begin
    head_bytes = '0;
    head_bytes[0 +: nbf_opcode_width_p]                 = head.opcode;
    head_bytes[OP_B*8 +: nbf_addr_width_p]              = head.addr;
    head_bytes[(OP_B+AD_B)*8 +: nbf_data_width_p]       = head.data;
  end

  // Packet FSM
  bp_fpga_host_nbf_tx_state_e state_q, state_d;
  logic [SW-1:0]    shift_q;
  logic [CNT_W-1:0] byte_cnt_q;
  logic [15:0]      pkt_count_q;
  logic             pkt_done_q, pkt_done_d;
  logic             ser_v, ser_ready, ser_done, ser_busy, accept, last;
  logic [7:0]       ser_byte;

  assign accept = ser_v & ser_ready;
  assign last   = (byte_cnt_q == CNT_W'(TOT - 1));

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_q <= e_idle;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      e_idle:  if (!empty)         state_d = e_send;
      e_send:  if (accept && last) state_d = e_wait;
      e_wait:  if (ser_done)       state_d = e_idle;
      default:                     state_d = e_idle;
    endcase
  end

`ifdef BP_FPGA_HOST_NBF_TX_CHECKSUM_EN
  logic [7:0] csum_q;
`endif

  always_comb begin
    deq        = (state_q == e_idle) & !empty;
    ser_v      = (state_q == e_send);
    pkt_done_d = (state_q == e_wait) & ser_done;
`ifdef BP_FPGA_HOST_NBF_TX_CHECKSUM_EN
    ser_byte   = (byte_cnt_q == CNT_W'(N)) ? csum_q : shift_q[7:0];
`else
    ser_byte   = shift_q[7:0];
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      shift_q     <= '0;
      byte_cnt_q  <= '0;
      pkt_count_q <= '0;
      pkt_done_q  <= 1'b0;
`ifdef BP_FPGA_HOST_NBF_TX_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      pkt_done_q <= pkt_done_d;
      if (pkt_done_d) pkt_count_q <= pkt_count_q + 1'b1;
      if (deq) begin
        shift_q    <= head_bytes;
        byte_cnt_q <= '0;
`ifdef BP_FPGA_HOST_NBF_TX_CHECKSUM_EN
        csum_q     <= '0;
`endif
      end else if (accept) begin
        shift_q    <= shift_q >> 8;
        byte_cnt_q <= byte_cnt_q + 1'b1;
`ifdef BP_FPGA_HOST_NBF_TX_CHECKSUM_EN
        csum_q     <= csum_q ^ ser_byte;
`endif
      end
    end
  end

  bp_fpga_host_uart_serializer #(
    .clk_per_bit_p(uart_clk_per_bit_p),
    .parity_bit_p (uart_parity_bit_p),
    .stop_bits_p  (uart_stop_bits_p)
  ) u_ser (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .data_i   (ser_byte),
    .v_i      (ser_v),
    .ready_o  (ser_ready),
    .tx_o     (tx_o),
    .busy_o   (ser_busy),
    .done_o   (ser_done)
  );

  assign busy_o      = !empty | (state_q != e_idle) | ser_busy;
  assign pkt_done_o  = pkt_done_q;
  assign pkt_count_o = pkt_count_q;

endmodule

// File: tb/tb_bp_fpga_host_nbf_tx.sv
// Scoreboard bench: stimulus queues expected UART frames, line monitors decode and compare.
module tb_bp_fpga_host_nbf_tx;

  localparam int CPB = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [111:0] nbf1 = '0;
  logic         v1 = 1'b0;
  logic         ready1, tx1, busy1, done1;
  logic [15:0]  cnt1;
  logic [23:0]  nbf2 = '0;
  logic         v2 = 1'b0;
  logic         ready2, tx2, busy2, done2;
  logic [15:0]  cnt2;

  always #5 clk = ~clk;

  bp_fpga_host_nbf_tx #(
    .nbf_opcode_width_p(8), .nbf_addr_width_p(40), .nbf_data_width_p(64),
    .buffer_els_p(2), .uart_clk_per_bit_p(CPB), .uart_parity_bit_p(0), .uart_stop_bits_p(1)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .nbf_i(nbf1), .nbf_v_i(v1), .nbf_ready_and_o(ready1),
    .tx_o(tx1), .busy_o(busy1), .pkt_done_o(done1), .pkt_count_o(cnt1)
  );

  // Parity + two stop bits on a narrow 3-byte packet.
  bp_fpga_host_nbf_tx #(
    .nbf_opcode_width_p(8), .nbf_addr_width_p(8), .nbf_data_width_p(8),
    .buffer_els_p(1), .uart_clk_per_bit_p(CPB), .uart_parity_bit_p(1), .uart_stop_bits_p(2)
  ) dut_par (
    .clk_i(clk), .reset_n_i(rst_n), .nbf_i(nbf2), .nbf_v_i(v2), .nbf_ready_and_o(ready2),
    .tx_o(tx2), .busy_o(busy2), .pkt_done_o(done2), .pkt_count_o(cnt2)
  );

  int n_chk = 0;
  int n_fail = 0;
  int bytes_seen = 0;
  int done_cnt1 = 0;
  int done_cnt2 = 0;
  bit saw_low = 1'b0;
  logic [7:0]  exp1_q[$];
  logic [11:0] exp2_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic line(input int which);
    return (which == 2) ? tx2 : tx1;
  endfunction

  // Detected on the first cycle of the start bit; sample each bit one cycle in.
  task automatic rx_frame(input int which, input int nbits, output logic [11:0] bits, output bit ok);
    bits = '0;
    ok = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      repeat ((i == 0) ? 1 : CPB) begin
        @(negedge clk);
        if (!rst_n) ok = 1'b0;
      end
      if (!ok) return;
      bits[i] = line(which);
    end
  endtask

  always begin : mon1
    logic [11:0] b;
    bit ok;
    @(negedge clk);
    if (rst_n && tx1 === 1'b0) begin
      rx_frame(1, 10, b, ok);
      if (ok) begin
        chk("frame1_start_stop", {b[9], b[0]}, 2'b10);
        if (exp1_q.size() == 0) chk("byte1_unexpected", {56'd0, b[8:1]}, 64'hFFFF);
        else chk("byte1", {56'd0, b[8:1]}, {56'd0, exp1_q.pop_front()});
        bytes_seen++;
      end
    end
  end

  always begin : mon2
    logic [11:0] b;
    bit ok;
    @(negedge clk);
    if (rst_n && tx2 === 1'b0) begin
      rx_frame(2, 12, b, ok);
      if (ok) begin
        if (exp2_q.size() == 0) chk("frame2_unexpected", {52'd0, b}, 64'hFFFF);
        else chk("frame2_bits", {52'd0, b}, {52'd0, exp2_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done1) done_cnt1++;
    if (rst_n && done2) done_cnt2++;
    if (rst_n && v1 && !ready1) saw_low = 1'b1;
  end

  task automatic push_pkt1(input logic [111:0] p);
    for (int i = 0; i < 14; i++) exp1_q.push_back(p[i*8 +: 8]);
  endtask

  // Holds the packet until accepted; expected bytes are queued at the accepting edge.
  task automatic send1(input logic [111:0] p, input bit auto_exp);
    int t;
    @(negedge clk);
    nbf1 = p;
    v1 = 1'b1;
    t = 0;
    while (!ready1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!ready1) chk("send1_timeout", 0, 1);
    @(posedge clk);
    if (auto_exp) push_pkt1(p);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((busy1 || busy2 || exp1_q.size() != 0 || exp2_q.size() != 0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk(name, (t < 20000) ? 1 : 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b0 [14];
    int t;
    // Reset / idle
    repeat (4) @(negedge clk);
    chk("reset_ready_low", ready1, 1'b0);
    chk("reset_tx_high", tx1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_tx", tx1, 1'b1);
    chk("idle_busy", busy1, 1'b0);
    chk("idle_count", cnt1, 16'd0);
    chk("idle_ready", ready1, 1'b1);
    chk("idle_done", done1, 1'b0);

    // Single packet with hand-listed byte stream
    b0 = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h88, 8'h77,
           8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    send1({64'h1122334455667788, 40'h00_8000_0000, 8'h03}, 1'b0);
    foreach (b0[i]) exp1_q.push_back(b0[i]);
    @(negedge clk);
    v1 = 1'b0;
    drain("single_drain");
    chk("single_bytes", bytes_seen, 14);
    chk("single_done_pulses", done_cnt1, 1);
    chk("single_count", cnt1, 16'd1);

    // Back-pressure: four packets back to back
    for (int k = 0; k < 4; k++)
      send1({64'hDEAD_BEEF_0000_0000 + 64'(k), 40'h00_8000_0000 + 40'(k * 8), 8'h03}, 1'b1);
    @(negedge clk);
    v1 = 1'b0;
    drain("bp_drain");
    chk("bp_ready_dropped", saw_low, 1'b1);
    chk("bp_bytes", bytes_seen, 70);
    chk("bp_done_pulses", done_cnt1, 5);
    chk("bp_count", cnt1, 16'd5);

    // Parity + 2 stop bits: frames {stop,stop,par,data,start} LSB first
    exp2_q.push_back(12'hE0E);
    exp2_q.push_back(12'hD4A);
    exp2_q.push_back(12'hC00);
    @(negedge clk);
    nbf2 = 24'h00A507;
    v2 = 1'b1;
    @(negedge clk);
    v2 = 1'b0;
    drain("par_drain");
    chk("par_done_pulses", done_cnt2, 1);
    chk("par_count", cnt2, 16'd1);

    // Reset during the sixth byte of a packet
    send1({64'hCAFE_F00D_1234_5678, 40'h00_0000_1000, 8'h03}, 1'b1);
    @(negedge clk);
    v1 = 1'b0;
    t = 0;
    while (bytes_seen < 75 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("mid_reach_byte5", (bytes_seen >= 75) ? 1 : 0, 1);
    repeat (12) @(negedge clk);
    chk("mid_in_frame", busy1, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_tx_high", tx1, 1'b1);
    chk("mid_count_cleared", cnt1, 16'd0);
    repeat (4) @(negedge clk);
    exp1_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_busy_after", busy1, 1'b0);
    repeat (300) @(negedge clk);
    chk("mid_tx_idle", tx1, 1'b1);
    chk("mid_no_done", done_cnt1, 5);
    chk("mid_count_zero", cnt1, 16'd0);
    chk("mid_no_more_bytes", bytes_seen, 75);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
